// File: rtl/sd_arb_pkg.sv
// Shared types for the SD read arbiter: sequencer states, requester indices and
// the round-robin pick used when both requesters ask at once.
package sd_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StNext,
        StFinish
    } arb_state_e;

    localparam logic PortImage = 1'b0;
    localparam logic PortAsset = 1'b1;

    // Caller guarantees at least one request is high.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            return ~last;
        end
        return req1;
    endfunction

endpackage

// File: rtl/sd_watchdog.sv
// Cycle counter that flags a hung SD read once it has been waiting too long.
// The clear input restarts the count; expire asserts on the counting cycle
// whose update brings the count to TIMEOUT-1.
module sd_watchdog #(
    parameter int unsigned TIMEOUT = 5_000_000,
    parameter int unsigned TO_W    = 24
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TO_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TO_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = enable && !clear && (count_d == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/sd_read_arbiter.sv
// Shares one SD read controller between the image loader (port 0) and the asset
// loader (port 1): round-robin per burst, one SD read per word, watchdog abort.
module sd_read_arbiter
    import sd_arb_pkg::*;
#(
    parameter logic [31:0] ADDR_STEP = 32'd1,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned TIMEOUT   = 5_000_000,
    parameter int unsigned TO_W      = 24
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             req0,
    input  logic [31:0]      addr0,
    input  logic [LEN_W-1:0] len0,
    output logic             gnt0,
    output logic             vld0,
    output logic             done0,
    output logic             err0,

    input  logic             req1,
    input  logic [31:0]      addr1,
    input  logic [LEN_W-1:0] len1,
    output logic             gnt1,
    output logic             vld1,
    output logic             done1,
    output logic             err1,

    output logic [31:0]      rdata,

    input  logic             sd_initialized,
    output logic [31:0]      sd_addr,
    output logic             sd_read_req,
    input  logic             sd_read_complete,
    input  logic [31:0]      sd_out,

    output logic             busy
);

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [31:0]      cur_addr_q, cur_addr_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic [1:0]       vld_q, vld_d;
    logic [1:0]       done_q, done_d;
    logic [1:0]       err_q, err_d;

    logic             grant_valid;
    logic             grant_port;
    logic [LEN_W-1:0] grant_len;
    logic [31:0]      grant_addr;

    logic             wd_clear;
    logic             wd_enable;
    logic             wd_expire;

    assign grant_valid = sd_initialized && (req0 || req1);
    assign grant_port  = rr_pick(req0, req1, last_q);
    assign grant_len   = grant_port ? len1 : len0;
    assign grant_addr  = grant_port ? addr1 : addr0;

    sd_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expire  (wd_expire)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    state_d = (grant_len == '0) ? StFinish : StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                // A completion arriving on the expiry cycle still counts as a good read.
                if (sd_read_complete) begin
                    state_d = StNext;
                end else if (wd_expire) begin
                    state_d = StIdle;
                end
            end
            StNext:   state_d = (remain_q == LEN_W'(1)) ? StFinish : StIssue;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy        = (state_q != StIdle);
        gnt0        = busy && (owner_q == PortImage);
        gnt1        = busy && (owner_q == PortAsset);
        sd_addr     = cur_addr_q;
        sd_read_req = (state_q == StIssue);
        wd_clear    = (state_q == StIssue);
        wd_enable   = (state_q == StWait);
        rdata       = rdata_q;
        vld0        = vld_q[PortImage];
        vld1        = vld_q[PortAsset];
        done0       = done_q[PortImage];
        done1       = done_q[PortAsset];
        err0        = err_q[PortImage];
        err1        = err_q[PortAsset];
    end

    // Datapath: burst context and the single-cycle status pulses.
    always_comb begin
        owner_d    = owner_q;
        last_d     = last_q;
        cur_addr_d = cur_addr_q;
        remain_d   = remain_q;
        rdata_d    = rdata_q;
        vld_d      = '0;
        done_d     = '0;
        err_d      = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    owner_d    = grant_port;
                    last_d     = grant_port;
                    cur_addr_d = grant_addr;
                    remain_d   = grant_len;
                end
            end
            StWait: begin
                if (sd_read_complete) begin
                    rdata_d        = sd_out;
                    vld_d[owner_q] = 1'b1;
                end else if (wd_expire) begin
                    err_d[owner_q] = 1'b1;
                end
            end
            StNext: begin
                remain_d   = remain_q - LEN_W'(1);
                cur_addr_d = cur_addr_q + ADDR_STEP;
            end
            StFinish: done_d[owner_q] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q    <= PortImage;
            last_q     <= PortAsset;
            cur_addr_q <= '0;
            remain_q   <= '0;
            rdata_q    <= '0;
            vld_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
        end else begin
            owner_q    <= owner_d;
            last_q     <= last_d;
            cur_addr_q <= cur_addr_d;
            remain_q   <= remain_d;
            rdata_q    <= rdata_d;
            vld_q      <= vld_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Directed bench for sd_read_arbiter: an SD responder model, a burst-level
// reference model checked every cycle, and literal checks per scenario.
module tb_sd_read_arbiter;

    localparam int          LEN_W   = 16;
    localparam int          TO      = 100;
    localparam int          SD_LAT  = 10;
    localparam logic [31:0] PAT     = 32'hA5A5A5A5;

    logic             clock;
    logic             reset;
    logic             req0, req1;
    logic [31:0]      addr0, addr1;
    logic [LEN_W-1:0] len0, len1;
    logic             gnt0, vld0, done0, err0;
    logic             gnt1, vld1, done1, err1;
    logic [31:0]      rdata;
    logic             sd_initialized;
    logic [31:0]      sd_addr;
    logic             sd_read_req;
    logic             sd_read_complete;
    logic [31:0]      sd_out;
    logic             busy;

    sd_read_arbiter #(
        .ADDR_STEP (32'd1),
        .LEN_W     (LEN_W),
        .TIMEOUT   (TO),
        .TO_W      (24)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .req0             (req0),
        .addr0            (addr0),
        .len0             (len0),
        .gnt0             (gnt0),
        .vld0             (vld0),
        .done0            (done0),
        .err0             (err0),
        .req1             (req1),
        .addr1            (addr1),
        .len1             (len1),
        .gnt1             (gnt1),
        .vld1             (vld1),
        .done1            (done1),
        .err1             (err1),
        .rdata            (rdata),
        .sd_initialized   (sd_initialized),
        .sd_addr          (sd_addr),
        .sd_read_req      (sd_read_req),
        .sd_read_complete (sd_read_complete),
        .sd_out           (sd_out),
        .busy             (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SD controller model: answers each strobe after SD_LAT cycles with addr^PAT,
    // but stops answering once sd_served exceeds sd_answer_limit.
    int          sd_cnt = 0;
    int          sd_served = 0;
    int          sd_answer_limit = 1000000;
    logic [31:0] sd_pend = '0;

    initial begin
        sd_read_complete = 1'b0;
        sd_out = '0;
        forever begin
            @(posedge clock);
            #1;
            sd_read_complete = 1'b0;
            if (sd_cnt > 0) begin
                sd_cnt--;
                if (sd_cnt == 0) begin
                    sd_read_complete = 1'b1;
                    sd_out = sd_pend ^ PAT;
                end
            end
            if (sd_read_req) begin
                sd_served++;
                if (sd_served <= sd_answer_limit) begin
                    sd_cnt = SD_LAT;
                    sd_pend = sd_addr;
                end
            end
        end
    end

    // Burst-level reference model, compared on every falling edge.
    initial begin : compare
        int          cyc, owner, len, left, vcnt, last_req, last_vld, port;
        logic [31:0] addr;
        logic        last, gany, exp_new;
        logic [31:0] expq[$];
        logic        p_idle, p_init, p_req0, p_req1;
        logic [31:0] p_addr0, p_addr1;
        logic [LEN_W-1:0] p_len0, p_len1;
        cyc = 0; owner = -1; len = 0; left = 0; vcnt = 0; last_req = 0; last_vld = 0;
        port = 0; addr = '0; last = 1'b1;
        p_idle = 1'b1; p_init = 1'b0; p_req0 = 1'b0; p_req1 = 1'b0;
        p_addr0 = '0; p_addr1 = '0; p_len0 = '0; p_len1 = '0;
        forever begin
            @(negedge clock);
            cyc++;
            gany = gnt0 | gnt1;
            if (!reset) begin
                check("reset_quiet",
                      {22'd0, gnt0, gnt1, busy, sd_read_req, vld0, vld1, done0, done1, err0, err1},
                      32'd0);
                owner = -1;
                last = 1'b1;
                left = 0;
                expq.delete();
            end else begin
                check("gnt_exclusive", gnt0 & gnt1, 1'b0);
                check("busy_vs_gnt", busy, gany);
                if (owner < 0) begin
                    check("no_stray_pulse", {vld0, vld1, done0, done1, err0, err1}, 6'd0);
                end else begin
                    if (vld0 | vld1) begin
                        check("vld_port", vld1, owner == 1);
                        check("vld_not_with_done", done0 | done1, 1'b0);
                        check("vld_has_read", expq.size() > 0, 1'b1);
                        if (expq.size() > 0) check("rdata", rdata, expq.pop_front());
                        vcnt++;
                        last_vld = cyc;
                    end
                    if (done0 | done1) begin
                        check("done_port", done1, owner == 1);
                        check("done_words", vcnt, len);
                        check("done_all_issued", left, 0);
                        if (len > 0) check("done_gap", cyc - last_vld, 2);
                        check("done_gnt_low", gany, 1'b0);
                        owner = -1;
                    end else if (err0 | err1) begin
                        check("err_port", err1, owner == 1);
                        check("err_delay", cyc - last_req, TO);
                        check("err_gnt_low", gany, 1'b0);
                        owner = -1;
                    end else begin
                        check("gnt_held", (owner == 1) ? gnt1 : gnt0, 1'b1);
                    end
                end
                if (owner < 0) begin
                    exp_new = p_idle && p_init && (p_req0 || p_req1);
                    check("grant_start", gany, exp_new);
                    if (gany && exp_new) begin
                        port = (p_req0 && p_req1) ? int'(!last) : int'(p_req1);
                        check("grant_port", gnt1, port == 1);
                        owner = port;
                        last = (port == 1);
                        addr = (port == 1) ? p_addr1 : p_addr0;
                        len = (port == 1) ? int'(p_len1) : int'(p_len0);
                        left = len;
                        vcnt = 0;
                        expq.delete();
                    end
                end
                if (sd_read_req) begin
                    check("read_req_owned", (owner >= 0) && (left > 0), 1'b1);
                    check("sd_addr", sd_addr, addr);
                    expq.push_back(addr ^ PAT);
                    addr = addr + 32'd1;
                    left--;
                    last_req = cyc;
                end
            end
            p_idle = !(gnt0 | gnt1);
            p_init = sd_initialized && reset;
            p_req0 = req0;
            p_req1 = req1;
            p_addr0 = addr0;
            p_addr1 = addr1;
            p_len0 = len0;
            p_len1 = len1;
        end
    end

    // Per-scenario observations, sampled 2 time units after each rising edge.
    int          mcyc = 0;
    logic [31:0] s_addrs[$];
    int          s_req_cyc[$];
    logic [31:0] s_data0[$];
    logic [31:0] s_grants[$];
    int s_vld0, s_vld1, s_done0, s_done1, s_err0, s_err_cyc, s_last_vld, s_done_gap;
    int s_overlap, s_gnt1_cyc, s_busy_cyc, s_cmpl;
    logic g0_prev, g1_prev;
    logic keep_req0, keep_req1;
    logic [31:0] got[$];
    logic [31:0] want[$];

    task automatic clear_stats();
        s_addrs.delete(); s_req_cyc.delete(); s_data0.delete(); s_grants.delete();
        s_vld0 = 0; s_vld1 = 0; s_done0 = 0; s_done1 = 0; s_err0 = 0; s_err_cyc = -1;
        s_last_vld = -1000; s_done_gap = -1; s_overlap = 0; s_gnt1_cyc = 0;
        s_busy_cyc = 0; s_cmpl = 0;
        g0_prev = gnt0; g1_prev = gnt1;
    endtask

    task automatic sample();
        if (sd_read_req) begin
            s_addrs.push_back(sd_addr);
            s_req_cyc.push_back(mcyc);
        end
        if (vld0) begin s_vld0++; s_data0.push_back(rdata); s_last_vld = mcyc; end
        if (vld1) begin s_vld1++; s_last_vld = mcyc; end
        if (done0 || done1) s_done_gap = mcyc - s_last_vld;
        if (done0) s_done0++;
        if (done1) s_done1++;
        if (err0) begin s_err0++; s_err_cyc = mcyc; end
        if (gnt0 && !g0_prev) s_grants.push_back(32'd0);
        if (gnt1 && !g1_prev) s_grants.push_back(32'd1);
        g0_prev = gnt0;
        g1_prev = gnt1;
        if (gnt0 && gnt1) s_overlap++;
        if (gnt1) s_gnt1_cyc++;
        if (busy) s_busy_cyc++;
        if (sd_read_complete) s_cmpl++;
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
        mcyc++;
        sample();
    endtask

    // Run until want_ends done/err pulses have been seen; requests drop on their end
    // unless held, and all drop once the last expected end arrives.
    task automatic observe(input int budget, input int want_ends);
        int ends = 0;
        int n = 0;
        while (ends < want_ends && n < budget) begin
            tick();
            n++;
            if (done0 || err0) begin ends++; if (!keep_req0) req0 = 1'b0; end
            if (done1 || err1) begin ends++; if (!keep_req1) req1 = 1'b0; end
            if (ends >= want_ends) begin req0 = 1'b0; req1 = 1'b0; end
        end
        check("burst_ends_in_budget", ends, want_ends);
    endtask

    task automatic cmp_seq(input string name);
        check({name, "_len"}, got.size(), want.size());
        for (int i = 0; i < want.size(); i++) begin
            check(name, (i < got.size()) ? got[i] : 32'hDEADBEEF, want[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        sd_initialized = 1'b1;
        keep_req0 = 1'b1; keep_req1 = 1'b0;
        req0 = 1'b1; addr0 = 32'h200; len0 = 16'd2;
        req1 = 1'b1; addr1 = 32'h300; len1 = 16'd2;

        // Reset state, then contention with both requests high out of reset.
        repeat (3) @(posedge clock);
        #2;
        check("rst_gnt", {gnt0, gnt1, busy, sd_read_req}, 4'd0);
        check("rst_sd_addr", sd_addr, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_pulses", {vld0, vld1, done0, done1, err0, err1}, 6'd0);
        clear_stats();
        reset = 1'b1;
        observe(300, 3);
        got = s_grants; want = {32'd0, 32'd1, 32'd0};
        cmp_seq("cont_grant_order");
        check("cont_overlap", s_overlap, 0);
        got = s_addrs; want = {32'h200, 32'h201, 32'h300, 32'h301, 32'h200, 32'h201};
        cmp_seq("cont_sd_addr");
        keep_req0 = 1'b0;
        repeat (3) tick();

        // Single burst on port 0.
        clear_stats();
        req0 = 1'b1; addr0 = 32'h100; len0 = 16'd3;
        observe(200, 1);
        got = s_addrs; want = {32'h100, 32'h101, 32'h102};
        cmp_seq("single_sd_addr");
        check("single_vld_count", s_vld0, 3);
        got = s_data0; want = {32'hA5A5A4A5, 32'hA5A5A4A4, 32'hA5A5A4A7};
        cmp_seq("single_data");
        check("single_done_count", s_done0, 1);
        check("single_done_gap", s_done_gap, 2);
        check("single_gnt1_idle", s_gnt1_cyc, 0);
        repeat (3) tick();

        // Zero-length burst on port 1.
        clear_stats();
        req1 = 1'b1; addr1 = 32'h700; len1 = 16'd0;
        observe(50, 1);
        check("zero_done1", s_done1, 1);
        check("zero_no_read", s_addrs.size(), 0);
        check("zero_no_vld", s_vld1, 0);
        repeat (3) tick();

        // Timeout: the second read of a 4-word burst never completes.
        clear_stats();
        sd_answer_limit = sd_served + 1;
        req0 = 1'b1; addr0 = 32'h400; len0 = 16'd4;
        observe(400, 1);
        check("to_vld_count", s_vld0, 1);
        check("to_err_count", s_err0, 1);
        check("to_no_done", s_done0, 0);
        check("to_read_count", s_addrs.size(), 2);
        check("to_err_delay", s_err_cyc - ((s_req_cyc.size() > 1) ? s_req_cyc[1] : -1000), TO);
        tick();
        check("to_idle", busy, 1'b0);
        sd_answer_limit = 1000000;
        repeat (3) tick();

        // Gating on sd_initialized, then address wrap.
        clear_stats();
        sd_initialized = 1'b0;
        req0 = 1'b1; addr0 = 32'hFFFFFFFF; len0 = 16'd2;
        repeat (50) tick();
        check("gate_no_grant", s_busy_cyc, 0);
        sd_initialized = 1'b1;
        observe(200, 1);
        check("gate_granted", s_grants.size(), 1);
        got = s_addrs; want = {32'hFFFFFFFF, 32'h00000000};
        cmp_seq("wrap_sd_addr");
        check("wrap_data1", (s_data0.size() > 1) ? s_data0[1] : 32'd0, 32'hA5A5A5A5);
        repeat (3) tick();

        // Asynchronous reset while waiting on the SD controller.
        clear_stats();
        req0 = 1'b1; addr0 = 32'h500; len0 = 16'd1;
        for (int n = 0; n < 20 && s_addrs.size() == 0; n++) tick();
        check("arst_issue_seen", s_addrs.size(), 1);
        repeat (3) tick();
        check("arst_pre_gnt", gnt0, 1'b1);
        req0 = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("arst_gnt0", gnt0, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_read_req", sd_read_req, 1'b0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        s_vld0 = 0; s_cmpl = 0;
        repeat (20) tick();
        check("arst_late_complete_seen", s_cmpl > 0, 1'b1);
        check("arst_no_vld", s_vld0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sd_read_arbiter.md
Name: sd_read_arbiter

Overview:
- Shares the single SD read controller between two requesters: the background/sprite image loader (port 0) and the score/sound asset loader (port 1).
- Each requester submits a burst: a base address and a count of 32-bit words.
- The block sequences one SD read per word, advances the address and streams each word back to the owning requester.
- Arbitration is round-robin per burst. A watchdog aborts a burst when the SD controller hangs.

Parameters:
- ADDR_STEP, 1: amount added to sd_addr after each word (1 = word/sector index, 4 = byte addressing).
- LEN_W, 16: width of the burst length field.
- TIMEOUT, 24'd5_000_000: max cycles in WAIT before abort.
- TO_W, 24: width of the watchdog counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req0  in  1  requester 0 burst request; level, held until done0/err0.
- addr0  in  32  requester 0 base address; sampled at grant.
- len0  in  LEN_W  requester 0 word count; sampled at grant.
- gnt0  out  1  high while requester 0 owns the SD controller.
- vld0  out  1  one-cycle pulse, data word for requester 0.
- done0  out  1  one-cycle pulse, burst 0 finished normally.
- err0  out  1  one-cycle pulse, burst 0 aborted by timeout.
- req1, addr1, len1, gnt1, vld1, done1, err1: same as port 0, for requester 1.
- rdata  out  32  word returned to the granted requester; valid when vldN=1.
- sd_initialized  in  1  SD controller initialized flag.
- sd_addr  out  32  address driven to the SD controller.
- sd_read_req  out  1  one-cycle read strobe to the SD controller.
- sd_read_complete  in  1  one-cycle pulse from the SD controller, sd_out valid.
- sd_out  in  32  read data from the SD controller.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs are 0, including sd_addr and rdata. Round-robin pointer last=1, so port 0 wins first.
- States: IDLE, ISSUE, WAIT, NEXT, FINISH.
- IDLE:
  - No grant is given while sd_initialized=0.
  - If only one reqN is high, grant N.
  - If both are high, grant the port != last.
  - On grant: latch addrN into cur_addr and lenN into remain, set gntN=1, set last=N.
  - If the latched length is 0, go directly to FINISH: doneN pulses and no SD access is made.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): sd_addr=cur_addr, sd_read_req=1. Clear the watchdog. Go to WAIT.
- WAIT:
  - sd_addr stays stable and sd_read_req=0.
  - On sd_read_complete: rdata<=sd_out, pulse vldN the next cycle, go to NEXT.
  - When the watchdog reaches TIMEOUT-1: pulse errN, drop gntN, return to IDLE. Discard the remaining words.
- NEXT (1 cycle):
  - remain<=remain-1 and cur_addr<=cur_addr+ADDR_STEP. The address wraps modulo 2^32.
  - If remain was 1, go to FINISH. Otherwise go to ISSUE.
- FINISH (1 cycle): pulse doneN, drop gntN, go to IDLE.
- Per-word cost: 2 cycles + SD latency, from ISSUE to the next ISSUE.
- Requester rules:
  - reqN dropping mid-burst does not abort the burst. The burst completes; the requester may ignore the data.
  - A new grant needs reqN=1 in IDLE after doneN/errN. A requester that keeps req high after done is re-arbitrated fairly, so alternation is guaranteed.
- Other events:
  - sd_read_complete outside WAIT is ignored.
  - sd_initialized falling mid-burst has no effect. The watchdog covers a hang.
- Output timing:
  - vld, done and err are registered outputs.
  - vld and done never coincide; done follows the last vld by 2 cycles.
- Reset mid-burst: immediate return to IDLE with all outputs 0. No pulses are emitted.

Decomposition:
- Package sd_arb_pkg: state enum (IDLE, ISSUE, WAIT, NEXT, FINISH) and requester index constants.
- Sub-module sd_watchdog: counter with clear/enable inputs and an expire output, parameterized by TIMEOUT/TO_W.
- Arbitration and sequencing stay in the top module.

Test Plan:
- Single burst: req0, addr0=0x100, len0=3, SD model returns addr^0xA5A5A5A5 after 10 cycles.
  - Required: sd_addr sequence 0x100, 0x101, 0x102.
  - Three vld0 pulses with the matching data, then done0 2 cycles after the last vld0. gnt1 stays 0.
- Contention: req0 and req1 both high from reset, each len=2.
  - Required: port 0 is served first, then port 1, then port 0 again if req0 is still held.
  - gnt0 and gnt1 are never both high.
- Zero length: len1=0.
  - Required: done1 pulses with no sd_read_req and no vld1.
- Timeout: TIMEOUT=100 in the bench, SD model never completes on the 2nd word of len0=4.
  - Required: one vld0, then err0 exactly 100 cycles after the second sd_read_req, no done0, return to IDLE.
- Gating and address wrap:
  - sd_initialized=0 with req0 high: no grant for 50 cycles; a grant comes after sd_initialized rises.
  - addr0=0xFFFFFFFF, len=2, ADDR_STEP=1: second sd_addr=0x00000000.
- Async reset in WAIT: drive reset=0 mid-cycle.
  - Required: gnt0, busy and sd_read_req go to 0 without waiting for a clock edge.
  - A later sd_read_complete produces no vld.
